// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants and FSM state type for the audio frame
//                scheduler that feeds the I2S bit serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int FRAME_W          = 16;  // bits per frame
    localparam int GROUP_BITS       = 64;  // bclk cycles per four-frame group
    localparam int FRAMES_PER_GROUP = 4;   // frames popped per reload

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scheduler_if
//  Description : Bundles the upstream sample handshake, the stream enable and
//                the serializer-facing outputs of the frame scheduler.
//                slave  : scheduler side (accepts samples, drives frames)
//                master : environment side (supplies samples, observes frames)
//  Signals     : enable, s_data, s_valid -> scheduler
//                s_ready, frame0..3, start, option, underrun, fill <- scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_scheduler_if #(
    parameter int DEPTH   = 8,
    parameter int FRAME_W = 16
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic                enable;
    logic [FRAME_W-1:0]  s_data;
    logic                s_valid;
    logic                s_ready;
    logic [FRAME_W-1:0]  frame0;
    logic [FRAME_W-1:0]  frame1;
    logic [FRAME_W-1:0]  frame2;
    logic [FRAME_W-1:0]  frame3;
    logic                start;
    logic                option;
    logic                underrun;
    logic [FILL_W-1:0]   fill;

    modport slave (
        input  enable, s_data, s_valid,
        output s_ready, frame0, frame1, frame2, frame3,
               start, option, underrun, fill
    );

    modport master (
        output enable, s_data, s_valid,
        input  s_ready, frame0, frame1, frame2, frame3,
               start, option, underrun, fill
    );

endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : DEPTH x FRAME_W sample buffer with single-word push and a
//                four-word pop. The four oldest entries are presented
//                combinationally (read-ahead) so a pop can load them at once.
//  Ports       : clk, rst (async, active-high)
//                push_data_i/push_valid_i/push_ready_o : upstream handshake
//                pop_i   : remove the four oldest words (caller ensures fill>=4)
//                rd_o    : four oldest entries, rd_o[0] is the oldest
//                fill_o  : current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH   = 8,
    parameter int FRAME_W = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int FILL_W  = $clog2(DEPTH) + 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [FRAME_W-1:0]     push_data_i,
    input  wire logic                   push_valid_i,
    output logic                        push_ready_o,
    input  wire logic                   pop_i,
    output logic [3:0][FRAME_W-1:0]     rd_o,
    output logic [FILL_W-1:0]           fill_o
);
    import audio_pkg::*;

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q,   fill_d;
    logic               w_push;

    // Ready comes from the registered fill, so a full FIFO can never overflow.
    assign push_ready_o = (fill_q < FILL_W'(DEPTH));
    assign w_push       = push_valid_i && push_ready_o;
    assign fill_o       = fill_q;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = fill_d + FILL_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(FRAMES_PER_GROUP);
            fill_d   = fill_d - FILL_W'(FRAMES_PER_GROUP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_rd
        assign rd_o[k] = mem_q[rd_ptr_q + AW'(k)];
    end

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scheduler
//  Description : Buffers upstream samples and loads four-frame groups onto
//                stable parallel outputs for the I2S serializer, reloading
//                every GROUP_BITS bclk cycles. Inserts a silent group and
//                pulses underrun when a boundary finds fewer than four words.
//  Ports       : bclk (sole clock), rst (async, active-high)
//                bus.slave : enable, s_data/s_valid/s_ready, frame0..3,
//                            start, option (word select), underrun, fill
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int DEPTH      = 8,
    parameter int FRAME_W    = 16,
    parameter int GROUP_BITS = 64
) (
    input  wire logic         bclk,
    input  wire logic         rst,
    frame_scheduler_if.slave  bus
);
    import audio_pkg::*;

    localparam int CNT_W  = $clog2(GROUP_BITS);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [3:0][FRAME_W-1:0]     frames_q, frames_d;
    logic                        start_q, start_d;
    logic                        underrun_q, underrun_d;

    logic                        w_pop;
    logic                        w_ready;
    logic [3:0][FRAME_W-1:0]     w_rd;
    logic [FILL_W-1:0]           w_fill;
    logic                        w_have_group;
    logic                        w_boundary;

    sample_fifo #(
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W)
    ) u_fifo (
        .clk          (bclk),
        .rst          (rst),
        .push_data_i  (bus.s_data),
        .push_valid_i (bus.s_valid),
        .push_ready_o (w_ready),
        .pop_i        (w_pop),
        .rd_o         (w_rd),
        .fill_o       (w_fill)
    );

    // Registered fill means a word pushed on this edge cannot count here.
    assign w_have_group = (w_fill >= FILL_W'(FRAMES_PER_GROUP));
    assign w_boundary   = (count_q == CNT_W'(GROUP_BITS - 1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        frames_d   = frames_q;
        start_d    = start_q;
        underrun_d = 1'b0;
        w_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                start_d = 1'b0;
                count_d = '0;
                if (bus.enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                start_d = 1'b0;
                count_d = '0;
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (w_have_group) begin
                    w_pop    = 1'b1;
                    frames_d = w_rd;
                    start_d  = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                start_d = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (w_boundary) begin
                    count_d = '0;
                    if (!bus.enable) begin
                        // Group has finished cleanly; FIFO keeps its contents.
                        start_d = 1'b0;
                        state_d = IDLE;
                    end else if (w_have_group) begin
                        w_pop    = 1'b1;
                        frames_d = w_rd;
                    end else begin
                        // Not enough data: play a silent group instead.
                        frames_d   = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            frames_q   <= '0;
            start_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            frames_q   <= frames_d;
            start_q    <= start_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.s_ready  = w_ready;
    assign bus.fill     = w_fill;
    assign bus.frame0   = frames_q[0];
    assign bus.frame1   = frames_q[1];
    assign bus.frame2   = frames_q[2];
    assign bus.frame3   = frames_q[3];
    assign bus.start    = start_q;
    assign bus.underrun = underrun_q;
    // Word select: low for frames 0-1, high for frames 2-3.
    assign bus.option   = count_q[CNT_W-1];

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scheduler
//  Description : Self-checking bench for frame_scheduler. A vector table
//                covers reset-to-first-group priming; directed sequences
//                cover underrun, seamless reload with simultaneous push/pop,
//                stop at group end, backpressure and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    logic bclk;
    logic rst;

    frame_scheduler_if #(.DEPTH(8), .FRAME_W(16)) bus ();

    frame_scheduler #(
        .DEPTH      (8),
        .FRAME_W    (16),
        .GROUP_BITS (64)
    ) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    int n_checks = 0;
    int n_err    = 0;

    // Bench-side model of the group counter while streaming.
    logic [5:0] m_cnt    = '0;
    logic       m_stream = 1'b0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        en;
        logic        rdy;
        logic [3:0]  fill;
        logic        start;
        logic        opt;
        logic        und;
        logic        chkf;
        logic [15:0] f0, f1, f2, f3;
    } vec_t;

    vec_t tbl [6];

    logic [15:0] wa [4];
    logic [15:0] wb [8];
    logic [15:0] wc [9];
    logic [15:0] wd [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_frames(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        chk({name, ".frame0"}, {16'h0, bus.frame0}, {16'h0, a});
        chk({name, ".frame1"}, {16'h0, bus.frame1}, {16'h0, b});
        chk({name, ".frame2"}, {16'h0, bus.frame2}, {16'h0, c});
        chk({name, ".frame3"}, {16'h0, bus.frame3}, {16'h0, d});
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic en);
        @(negedge bclk);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.enable  = en;
        @(posedge bclk);
        #1;
        if (m_stream) begin
            m_cnt = (m_cnt == 6'd63) ? 6'd0 : m_cnt + 6'd1;
            chk("option", {31'h0, bus.option}, {31'h0, m_cnt[5]});
            if (m_cnt != 6'd0) begin
                chk("start_mid", {31'h0, bus.start}, 32'd1);
                chk("underrun_mid", {31'h0, bus.underrun}, 32'd0);
            end
        end
    endtask

    task automatic run_until(input logic [5:0] target, input logic en);
        while (m_cnt != target) step(1'b0, 16'h0, en);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h1111, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[1] = '{1'b1, 16'h2222, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[2] = '{1'b1, 16'h3333, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[3] = '{1'b1, 16'h4444, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) wa[i] = 16'hA001 + 16'(i);
        for (int i = 0; i < 8; i++) wb[i] = 16'hB001 + 16'(i);
        for (int i = 0; i < 9; i++) wc[i] = 16'hC001 + 16'(i);
        for (int i = 0; i < 3; i++) wd[i] = 16'hD001 + 16'(i);

        // ---------------- reset state ----------------
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0;
        repeat (2) @(posedge bclk);
        #1;
        chk("rst.s_ready", {31'h0, bus.s_ready}, 32'd1);
        chk("rst.fill", {28'h0, bus.fill}, 32'd0);
        chk("rst.start", {31'h0, bus.start}, 32'd0);
        chk("rst.option", {31'h0, bus.option}, 32'd0);
        chk("rst.underrun", {31'h0, bus.underrun}, 32'd0);
        chk_frames("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge bclk);
        rst = 1'b0;

        // ---------------- prime: table-driven ----------------
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].en);
            chk($sformatf("prime%0d.s_ready", i), {31'h0, bus.s_ready}, {31'h0, tbl[i].rdy});
            chk($sformatf("prime%0d.fill", i), {28'h0, bus.fill}, {28'h0, tbl[i].fill});
            chk($sformatf("prime%0d.start", i), {31'h0, bus.start}, {31'h0, tbl[i].start});
            chk($sformatf("prime%0d.option", i), {31'h0, bus.option}, {31'h0, tbl[i].opt});
            chk($sformatf("prime%0d.underrun", i), {31'h0, bus.underrun}, {31'h0, tbl[i].und});
            if (tbl[i].chkf)
                chk_frames($sformatf("prime%0d", i), tbl[i].f0, tbl[i].f1, tbl[i].f2, tbl[i].f3);
        end
        m_stream = 1'b1;
        m_cnt    = 6'd1;

        // ---------------- underrun ----------------
        run_until(6'd63, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("under.pulse", {31'h0, bus.underrun}, 32'd1);
        chk("under.start", {31'h0, bus.start}, 32'd1);
        chk("under.fill", {28'h0, bus.fill}, 32'd0);
        chk_frames("under", 16'h0, 16'h0, 16'h0, 16'h0);
        step(1'b0, 16'h0, 1'b1);
        chk("under.one_cycle", {31'h0, bus.underrun}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, wa[i], 1'b1);
        chk("refill.fill", {28'h0, bus.fill}, 32'd4);
        chk_frames("under.silent_hold", 16'h0, 16'h0, 16'h0, 16'h0);
        run_until(6'd63, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk_frames("refill", wa[0], wa[1], wa[2], wa[3]);
        chk("refill.underrun", {31'h0, bus.underrun}, 32'd0);
        chk("refill.fill_after", {28'h0, bus.fill}, 32'd0);

        // ---------------- seamless + simultaneous push/pop ----------------
        for (int i = 0; i < 5; i++) step(1'b1, wb[i], 1'b1);
        chk("pp.fill5", {28'h0, bus.fill}, 32'd5);
        run_until(6'd63, 1'b1);
        step(1'b1, wb[5], 1'b1);
        chk("pp.fill2", {28'h0, bus.fill}, 32'd2);
        chk("pp.underrun", {31'h0, bus.underrun}, 32'd0);
        chk("pp.start", {31'h0, bus.start}, 32'd1);
        chk_frames("pp.grp1", wb[0], wb[1], wb[2], wb[3]);
        step(1'b1, wb[6], 1'b1);
        step(1'b1, wb[7], 1'b1);
        chk("pp.fill4", {28'h0, bus.fill}, 32'd4);
        run_until(6'd63, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk_frames("pp.grp2", wb[4], wb[5], wb[6], wb[7]);
        chk("pp.fill0", {28'h0, bus.fill}, 32'd0);
        chk("pp.underrun2", {31'h0, bus.underrun}, 32'd0);

        // ---------------- stop at group end ----------------
        run_until(6'd10, 1'b1);
        run_until(6'd63, 1'b0);
        chk("stop.start_before", {31'h0, bus.start}, 32'd1);
        step(1'b0, 16'h0, 1'b0);
        m_stream = 1'b0;
        chk("stop.start", {31'h0, bus.start}, 32'd0);
        chk("stop.option", {31'h0, bus.option}, 32'd0);
        chk("stop.underrun", {31'h0, bus.underrun}, 32'd0);
        chk_frames("stop.hold", wb[4], wb[5], wb[6], wb[7]);
        step(1'b0, 16'h0, 1'b0);
        chk("stop.idle_start", {31'h0, bus.start}, 32'd0);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 9; i++) begin
            step(1'b1, wc[i], 1'b0);
            chk($sformatf("bp%0d.fill", i), {28'h0, bus.fill}, (i < 8) ? i + 1 : 8);
            chk($sformatf("bp%0d.s_ready", i), {31'h0, bus.s_ready}, (i < 7) ? 32'd1 : 32'd0);
        end
        step(1'b0, 16'h0, 1'b1);
        chk("bp.prime_start", {31'h0, bus.start}, 32'd0);
        chk("bp.prime_fill", {28'h0, bus.fill}, 32'd8);
        step(1'b0, 16'h0, 1'b1);
        chk_frames("bp.grp1", wc[0], wc[1], wc[2], wc[3]);
        chk("bp.start", {31'h0, bus.start}, 32'd1);
        chk("bp.fill4", {28'h0, bus.fill}, 32'd4);
        chk("bp.s_ready", {31'h0, bus.s_ready}, 32'd1);
        m_stream = 1'b1;
        m_cnt    = 6'd0;
        run_until(6'd63, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk_frames("bp.grp2", wc[4], wc[5], wc[6], wc[7]);
        chk("bp.fill0", {28'h0, bus.fill}, 32'd0);

        // ---------------- asynchronous reset mid-group ----------------
        for (int i = 0; i < 3; i++) step(1'b1, wd[i], 1'b1);
        run_until(6'd20, 1'b1);
        chk("arst.fill_before", {28'h0, bus.fill}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.start", {31'h0, bus.start}, 32'd0);
        chk("arst.fill", {28'h0, bus.fill}, 32'd0);
        chk("arst.s_ready", {31'h0, bus.s_ready}, 32'd1);
        chk("arst.option", {31'h0, bus.option}, 32'd0);
        chk("arst.underrun", {31'h0, bus.underrun}, 32'd0);
        chk_frames("arst", 16'h0, 16'h0, 16'h0, 16'h0);
        m_stream = 1'b0;
        @(negedge bclk);
        rst = 1'b0;
        bus.enable  = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) @(posedge bclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
